// File: rtl/stream_master_fifo_if.sv
// stream_master_fifo_if
//   AXI4-Stream master bus between the output buffer and its downstream sink.
//
//   Handshake: a word moves on the rising clock edge where M_AXIS_TVALID and
//   M_AXIS_TREADY are both 1. Once the master raises TVALID it holds TVALID,
//   TDATA, TSTRB and TLAST unchanged until that transfer edge. The slave may
//   drive TREADY freely, and it may depend on TVALID.
//
//   Signals:
//     M_AXIS_TVALID  master -> slave  word valid
//     M_AXIS_TDATA   master -> slave  payload
//     M_AXIS_TSTRB   master -> slave  byte strobes (all ones)
//     M_AXIS_TLAST   master -> slave  last word of a packet
//     M_AXIS_TREADY  slave -> master  sink accepts
interface stream_master_fifo_if #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32
);
    logic                              M_AXIS_TVALID;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA;
    logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB;
    logic                              M_AXIS_TLAST;
    logic                              M_AXIS_TREADY;

    modport master (
        output M_AXIS_TVALID,
        output M_AXIS_TDATA,
        output M_AXIS_TSTRB,
        output M_AXIS_TLAST,
        input  M_AXIS_TREADY
    );

    modport slave (
        input  M_AXIS_TVALID,
        input  M_AXIS_TDATA,
        input  M_AXIS_TSTRB,
        input  M_AXIS_TLAST,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/stream_master_fifo.sv
// stream_master_fifo
//   AXI4-Stream master output buffer. Filter results arrive on a simple
//   valid/data/last write port, are held in a DEPTH-entry first-word-fall-
//   through FIFO and leave on the M_AXIS bus. Provides registered almost-full
//   backpressure (is_ready), an occupancy count, sticky overflow with drop,
//   and an optional store-and-forward packet mode.
//
//   Ports:
//     M_AXIS_ACLK     clock for all logic
//     M_AXIS_ARESET   synchronous active-high reset
//     m_axis          AXI4-Stream master bus (stream_master_fifo_if.master)
//     in_valid        write strobe
//     in_data         write payload
//     in_last         final word of a packet
//     is_ready        registered permission for the upstream to write
//     level           current occupancy, 0..DEPTH
//     overflow        sticky, set when a write is dropped on a full FIFO
//     clr_overflow    clears overflow (a simultaneous drop wins)
module stream_master_fifo #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int DEPTH                = 32,
    parameter int AFULL_MARGIN         = 2,
    parameter int PACKET_MODE          = 0
) (
    input  logic                            M_AXIS_ACLK,
    input  logic                            M_AXIS_ARESET,
    stream_master_fifo_if.master            m_axis,
    input  logic                            in_valid,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0] in_data,
    input  logic                            in_last,
    output logic                            is_ready,
    output logic [$clog2(DEPTH):0]          level,
    output logic                            overflow,
    input  logic                            clr_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] READY_LIMIT = PW'(DEPTH - AFULL_MARGIN);

    logic [C_M_AXIS_TDATA_WIDTH-1:0] mem_data [DEPTH];
    logic                            mem_last [DEPTH];

    // Pointers carry one extra wrap bit so full and empty differ only there.
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] pkt_cnt;
    logic [PW-1:0] wptr_next;
    logic [PW-1:0] rptr_next;
    logic [PW-1:0] level_next;

    logic                            empty;
    logic                            full;
    logic                            wr_en;
    logic                            rd_en;
    logic                            tvalid;
    logic                            head_last;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] head_data;
    logic                            pkt_inc;
    logic                            pkt_dec;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

    assign head_data = mem_data[rptr[AW-1:0]];
    assign head_last = mem_last[rptr[AW-1:0]];

    // Packet mode waits for a complete packet, except when the FIFO is full:
    // a packet longer than DEPTH could never complete, so it streams through.
    always_comb begin
        tvalid = !empty;
        if (PACKET_MODE != 0) begin
            tvalid = !empty && ((pkt_cnt != '0) || full);
        end
    end

    // Full is judged on pre-edge state, so a write into a full FIFO is dropped
    // even when a read frees an entry at the same edge.
    assign wr_en = in_valid && !full;
    assign rd_en = tvalid && m_axis.M_AXIS_TREADY;

    assign wptr_next  = wptr + PW'(wr_en);
    assign rptr_next  = rptr + PW'(rd_en);
    assign level_next = wptr_next - rptr_next;
    assign level      = wptr - rptr;

    assign pkt_inc = wr_en && in_last;
    assign pkt_dec = rd_en && head_last;

    assign m_axis.M_AXIS_TVALID = tvalid;
    assign m_axis.M_AXIS_TDATA  = tvalid ? head_data : '0;
    assign m_axis.M_AXIS_TLAST  = tvalid && head_last;
    assign m_axis.M_AXIS_TSTRB  = '1;

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            wptr     <= '0;
            rptr     <= '0;
            pkt_cnt  <= '0;
            overflow <= 1'b0;
            is_ready <= 1'b0;
        end else begin
            wptr     <= wptr_next;
            rptr     <= rptr_next;
            // Looks at post-edge occupancy; still one cycle behind the
            // upstream's view, which AFULL_MARGIN has to absorb.
            is_ready <= (level_next < READY_LIMIT);
            if (in_valid && full) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (wr_en) begin
            mem_data[wptr[AW-1:0]] <= in_data;
            mem_last[wptr[AW-1:0]] <= in_last;
        end
    end
endmodule
